// File: rtl/uart_pkg.sv
// Shared UART definitions used by the transmit sequencer and the receiver.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_e;

  localparam logic UART_IDLE_LEVEL = 1'b1;
  localparam int   UART_CLKS_PER_BIT_DEFAULT = 5000;

  // Even parity bit over a byte; narrower frames are zero-extended by the caller.
  function automatic logic even_parity8(input logic [7:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/baud_tick_gen.sv
// Bit-period divider: counts 0..CLKS_PER_BIT-1 and restarts on demand so a new
// frame's start bit is aligned to the accept cycle.
module baud_tick_gen
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT_DEFAULT
) (
  input  logic Clk,
  input  logic Reset,
  input  logic restart,
  output logic bit_end,
  output logic bit_pre_end
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(CLKS_PER_BIT - 2);

  logic [CNT_W-1:0] count_r;

  // Divider counter, cleared on restart and wrapped at the end of each bit.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      count_r <= {CNT_W{1'b0}};
    end else if (restart || bit_end) begin
      count_r <= {CNT_W{1'b0}};
    end else begin
      count_r <= count_r + CNT_W'(1);
    end
  end

  // bit_pre_end lets the sequencer register tx_ready for the final stop cycle.
  assign bit_end     = (count_r == CNT_LAST);
  assign bit_pre_end = (count_r == CNT_PRE);

endmodule

// File: rtl/uart_tx_sequencer.sv
// UART transmit sequencer: start bit, data LSB first, optional even parity
// (compiled in with UART_TX_PARITY_EN), then STOP_BITS stop bits.
module uart_tx_sequencer
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT_DEFAULT,
  parameter int DATA_BITS    = 8,
  parameter int STOP_BITS    = 1
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx,
  output logic                 busy
);

  localparam int IDX_W = $clog2(DATA_BITS + 1);
  localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(DATA_BITS - 1);
  localparam logic [IDX_W-1:0] STOP_LAST = IDX_W'(STOP_BITS - 1);

  uart_state_e          state_r, state_s;
  logic [IDX_W-1:0]     bit_idx_r, bit_idx_s;
  logic [DATA_BITS-1:0] shift_r, shift_s;
  logic                 tx_r, tx_s;
  logic                 tx_ready_r, tx_ready_s;
  logic                 busy_r, busy_s;
  logic                 accept_s, bit_end_s, bit_pre_end_s;
`ifdef UART_TX_PARITY_EN
  logic                 parity_r;
`endif

  assign accept_s = tx_valid && tx_ready_r;

  baud_tick_gen #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .Clk         (Clk),
    .Reset       (Reset),
    .restart     (accept_s),
    .bit_end     (bit_end_s),
    .bit_pre_end (bit_pre_end_s)
  );

  // State, datapath and registered outputs.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_r    <= IDLE;
      bit_idx_r  <= {IDX_W{1'b0}};
      shift_r    <= {DATA_BITS{1'b0}};
      tx_r       <= UART_IDLE_LEVEL;
      tx_ready_r <= 1'b1;
      busy_r     <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_r   <= 1'b0;
`endif
    end else begin
      state_r    <= state_s;
      bit_idx_r  <= bit_idx_s;
      shift_r    <= shift_s;
      tx_r       <= tx_s;
      tx_ready_r <= tx_ready_s;
      busy_r     <= busy_s;
`ifdef UART_TX_PARITY_EN
      if (accept_s) begin
        parity_r <= even_parity8(8'(tx_data));
      end
`endif
    end
  end

  // Next-state logic; bit_idx counts data bits and then stop bits.
  always_comb begin
    state_s   = state_r;
    bit_idx_s = bit_idx_r;
    shift_s   = shift_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_s   = START;
          shift_s   = tx_data;
          bit_idx_s = {IDX_W{1'b0}};
        end else begin
          state_s = IDLE;
        end
      end
      START: begin
        if (bit_end_s) begin
          state_s   = DATA;
          bit_idx_s = {IDX_W{1'b0}};
        end else begin
          state_s = START;
        end
      end
      DATA: begin
        if (bit_end_s) begin
          shift_s = {1'b0, shift_r[DATA_BITS-1:1]};
          if (bit_idx_r == DATA_LAST) begin
            bit_idx_s = {IDX_W{1'b0}};
`ifdef UART_TX_PARITY_EN
            state_s   = PARITY;
`else
            state_s   = STOP;
`endif
          end else begin
            bit_idx_s = bit_idx_r + IDX_W'(1);
          end
        end else begin
          state_s = DATA;
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_end_s) begin
          state_s   = STOP;
          bit_idx_s = {IDX_W{1'b0}};
        end else begin
          state_s = PARITY;
        end
      end
`endif
      STOP: begin
        // tx_ready is only high in the last stop cycle, so accept implies bit end.
        if (accept_s) begin
          state_s   = START;
          shift_s   = tx_data;
          bit_idx_s = {IDX_W{1'b0}};
        end else if (bit_end_s) begin
          if (bit_idx_r == STOP_LAST) begin
            state_s   = IDLE;
            bit_idx_s = {IDX_W{1'b0}};
          end else begin
            bit_idx_s = bit_idx_r + IDX_W'(1);
          end
        end else begin
          state_s = STOP;
        end
      end
      default: begin
        state_s   = IDLE;
        bit_idx_s = {IDX_W{1'b0}};
      end
    endcase
  end

  // Output values for the next cycle, derived from the next state.
  always_comb begin
    tx_s   = UART_IDLE_LEVEL;
    busy_s = 1'b1;
    case (state_s)
      IDLE: begin
        tx_s   = UART_IDLE_LEVEL;
        busy_s = 1'b0;
      end
      START:  tx_s = ~UART_IDLE_LEVEL;
      DATA:   tx_s = shift_s[0];
`ifdef UART_TX_PARITY_EN
      PARITY: tx_s = parity_r;
`endif
      STOP:   tx_s = UART_IDLE_LEVEL;
      default: begin
        tx_s   = UART_IDLE_LEVEL;
        busy_s = 1'b0;
      end
    endcase
    if (state_s == IDLE) begin
      tx_ready_s = 1'b1;
    end else if ((state_r == STOP) && (bit_idx_r == STOP_LAST) && bit_pre_end_s) begin
      tx_ready_s = 1'b1;
    end else begin
      tx_ready_s = 1'b0;
    end
  end

  assign tx       = tx_r;
  assign tx_ready = tx_ready_r;
  assign busy     = busy_r;

endmodule

// File: tb/tb_uart_tx_sequencer.sv
// Scoreboard bench for uart_tx_sequencer (CLKS_PER_BIT=4, DATA_BITS=8, STOP_BITS=1).
module tb_uart_tx_sequencer;

  localparam int CPB = 4;
  localparam int DB  = 8;
  localparam int SB  = 1;
`ifdef UART_TX_PARITY_EN
  localparam int PB  = 1;
`else
  localparam int PB  = 0;
`endif
  localparam int NBITS = 1 + DB + PB + SB;
  localparam int FRAME = CPB * NBITS;

  typedef struct packed {
    logic tx;
    logic ready;
    logic busy;
  } exp_t;

  logic       Clk      = 1'b0;
  logic       Reset    = 1'b1;
  logic       tx_valid = 1'b0;
  logic [7:0] tx_data  = 8'h00;
  logic       tx_ready, tx, busy;

  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];

  always #5 Clk = ~Clk;

  uart_tx_sequencer #(
    .CLKS_PER_BIT (CPB),
    .DATA_BITS    (DB),
    .STOP_BITS    (SB)
  ) dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .tx       (tx),
    .busy     (busy)
  );

  task automatic check(input string name, input logic [2:0] act, input logic [2:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: tx/ready/busy got %b expected %b", name, $time, act, exp);
    end
  endtask

  // Expected per-cycle line state for one frame, starting at the accept edge.
  task automatic push_frame(input logic [7:0] d);
    logic bits [0:NBITS-1];
    exp_t e;
    bits[0] = 1'b0;
    for (int i = 0; i < DB; i++) bits[1+i] = d[i];
`ifdef UART_TX_PARITY_EN
    bits[1+DB] = ^d;
`endif
    bits[NBITS-1] = 1'b1;
    for (int b = 0; b < NBITS; b++) begin
      for (int c = 0; c < CPB; c++) begin
        e.tx    = bits[b];
        e.ready = (b == NBITS-1) && (c == CPB-1);
        e.busy  = 1'b1;
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic send(input logic [7:0] d);
    @(negedge Clk);
    tx_valid = 1'b1;
    tx_data  = d;
    push_frame(d);
    @(negedge Clk);
    tx_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 300; i++) begin
      if (exp_q.size() == 0) break;
      @(negedge Clk);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected cycles left, required 0", exp_q.size());
      exp_q.delete();
    end
    repeat (3) @(negedge Clk);
  endtask

  // Monitor: one comparison per cycle; an empty queue means the line must be idle.
  always @(posedge Clk) begin
    exp_t e;
    #1;
    if (!Reset) begin
      if (exp_q.size() != 0) e = exp_q.pop_front();
      else e = 3'b110;
      check("line", {tx, tx_ready, busy}, e);
    end
  end

  initial begin
    repeat (3) @(negedge Clk);
    check("reset_state", {tx, tx_ready, busy}, 3'b110);
    Reset = 1'b0;
    repeat (20) @(negedge Clk);

    send(8'hA5);
    drain();
    send(8'h07);
    drain();

    // Back-to-back: valid stays high, second frame follows with no gap.
    @(negedge Clk);
    tx_valid = 1'b1;
    tx_data  = 8'h00;
    push_frame(8'h00);
    @(negedge Clk);
    tx_data = 8'hFF;
    push_frame(8'hFF);
    repeat (FRAME) @(negedge Clk);
    tx_valid = 1'b0;
    drain();

    // Data hold: tx_data changes after accept must not affect the frame.
    @(negedge Clk);
    tx_valid = 1'b1;
    tx_data  = 8'h3C;
    push_frame(8'h3C);
    @(negedge Clk);
    tx_valid = 1'b0;
    repeat (2) @(negedge Clk);
    tx_data = 8'hC3;
    drain();

    // Mid-frame reset during data bit 3 of 0x00.
    @(negedge Clk);
    tx_valid = 1'b1;
    tx_data  = 8'h00;
    push_frame(8'h00);
    @(negedge Clk);
    tx_valid = 1'b0;
    repeat (17) @(negedge Clk);
    check("pre_reset_low", {tx, tx_ready, busy}, 3'b001);
    Reset = 1'b1;
    exp_q.delete();
    #1;
    check("reset_async", {tx, tx_ready, busy}, 3'b110);
    @(negedge Clk);
    check("reset_hold", {tx, tx_ready, busy}, 3'b110);
    Reset = 1'b0;
    repeat (12) @(negedge Clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
